// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional misaligned-fetch check is enabled by defining FETCH_ALIGN_CHK_EN.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DROP  = 3'd4
  } fetch_state_t;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
    logic               exc;
  } if_slot_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid buffer holding a fetched {instr, pc, exc} while decode is stalled.
// Clear wins over load so a redirect always empties it.
module fetch_hold_buf
  import fetch_pkg::*;
#(
  parameter int LENGTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [LENGTH-1:0]  d_pc,
  input  logic               d_exc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [LENGTH-1:0]  pc,
  output logic               exc
);

  logic               valid_d, valid_q;
  logic [INSTR_W-1:0] instr_d, instr_q;
  logic [LENGTH-1:0]  pc_d, pc_q;
  logic               exc_d, exc_q;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    exc_d   = exc_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = d_instr;
      pc_d    = d_pc;
      exc_d   = d_exc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
      exc_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      exc_q   <= exc_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;
  assign exc   = exc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one read per PC, latency absorption, IF/ID slot and PC write enable.
// FETCH_ALIGN_CHK_EN turns misaligned PCs into an exception slot instead of a fetch.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int LENGTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LENGTH-1:0]  pc_q,
  output logic               pc_wr,
  input  logic               redirect,
  output logic               mem_req,
  output logic [LENGTH-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               id_stall,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [LENGTH-1:0]  if_pc,
  output logic               if_exc,
  output logic [2:0]         dbg_state
);

  fetch_state_t       state_d, state_q;
  logic [LENGTH-1:0]  req_pc_d, req_pc_q;
  logic               if_valid_d, if_valid_q;
  logic [INSTR_W-1:0] if_instr_d, if_instr_q;
  logic [LENGTH-1:0]  if_pc_d, if_pc_q;
  logic               if_exc_d, if_exc_q;
  logic               halt_d, halt_q;

  logic               misalign, slot_free;
  logic               ld_slot, buf_load, buf_clear;
  logic [INSTR_W-1:0] ld_instr;
  logic [LENGTH-1:0]  ld_pc;
  logic               ld_exc;
  logic               buf_valid, buf_exc;
  logic [INSTR_W-1:0] buf_instr;
  logic [LENGTH-1:0]  buf_pc;

`ifdef FETCH_ALIGN_CHK_EN
  assign misalign = (pc_q[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign slot_free = !if_valid_q || !id_stall;

  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_exc_d   = if_exc_q;
    halt_d     = halt_q;
    pc_wr      = 1'b0;
    mem_req    = 1'b0;
    ld_slot    = 1'b0;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    ld_instr   = mem_rdata;
    ld_pc      = req_pc_q;
    ld_exc     = 1'b0;
    if (!id_stall) if_valid_d = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        // A halted stage sits in FETCH issuing nothing until a redirect.
        if (!halt_q) begin
          if (misalign) begin
            halt_d   = 1'b1;
            ld_instr = NOP;
            ld_pc    = pc_q;
            ld_exc   = 1'b1;
            if (slot_free) begin
              ld_slot = 1'b1;
            end else begin
              buf_load = 1'b1;
              state_d  = HOLD;
            end
          end else begin
            mem_req  = 1'b1;
            req_pc_d = pc_q;
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_ready) begin
          if (slot_free) begin
            ld_slot = 1'b1;
            pc_wr   = 1'b1;
            state_d = FETCH;
          end else begin
            buf_load = 1'b1;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (!id_stall && buf_valid) begin
          ld_slot   = 1'b1;
          ld_instr  = buf_instr;
          ld_pc     = buf_pc;
          ld_exc    = buf_exc;
          pc_wr     = !buf_exc;
          buf_clear = 1'b1;
          state_d   = FETCH;
        end
      end
      DROP: if (mem_ready) state_d = FETCH;
      default: state_d = IDLE;
    endcase

    if (ld_slot) begin
      if_valid_d = 1'b1;
      if_instr_d = ld_instr;
      if_pc_d    = ld_pc;
      if_exc_d   = ld_exc;
    end

    // Redirect overrides everything decided above; an outstanding read becomes an orphan.
    if (redirect) begin
      pc_wr      = (state_q != IDLE);
      if_valid_d = 1'b0;
      buf_load   = 1'b0;
      buf_clear  = 1'b1;
      halt_d     = 1'b0;
      case (state_q)
        FETCH:       state_d = mem_req ? DROP : FETCH;
        WAIT, DROP:  state_d = mem_ready ? FETCH : DROP;
        default:     state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      req_pc_q   <= '0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      if_exc_q   <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_pc_q   <= req_pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_exc_q   <= if_exc_d;
      halt_q     <= halt_d;
    end
  end

  fetch_hold_buf #(.LENGTH(LENGTH)) u_hold_buf (
    .clk     (clk),
    .reset   (reset),
    .load    (buf_load),
    .clear   (buf_clear),
    .d_instr (ld_instr),
    .d_pc    (ld_pc),
    .d_exc   (ld_exc),
    .valid   (buf_valid),
    .instr   (buf_instr),
    .pc      (buf_pc),
    .exc     (buf_exc)
  );

  assign mem_addr  = mem_req ? {pc_q[LENGTH-1:2], 2'b00} : '0;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign if_exc    = if_exc_q;
  assign dbg_state = state_q;

`ifndef SYNTHESIS
  a_no_ready_outside_wait: assert property (@(posedge clk) disable iff (reset)
    !(mem_ready && (state_q == IDLE || state_q == FETCH)));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: PC register and variable-latency memory models,
// with an in-order scoreboard of expected IF/ID slots {exc, pc, instr}.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_reg = '0;
  logic        pc_wr;
  logic        redirect = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        id_stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_exc;
  logic [2:0]  dbg_state;

  logic [31:0] target = '0;
  int          checks = 0;
  int          errors = 0;
  logic [64:0] exp_q[$];
  logic [64:0] exp_w;
  int          take_q[$];
  int          cyc = 0;
  logic        pend = 1'b0;
  int          due = 0;
  logic [31:0] pend_addr = '0;
  int          cur_lat = 1;
  logic        rand_lat = 1'b0;
  logic        sb_on = 1'b0;
  logic        pc_wr_s = 1'b0;
  logic        redir_s = 1'b0;
  logic [31:0] tgt_s = '0;
  int          pc_wr_cnt = 0;

  always #5 clk = ~clk;

  fetch_unit #(.LENGTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_q      (pc_reg),
    .pc_wr     (pc_wr),
    .redirect  (redirect),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .id_stall  (id_stall),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .if_exc    (if_exc),
    .dbg_state (dbg_state)
  );

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEAD_BEEF;
    return (a * 32'd3) ^ 32'h5A00_0000;
  endfunction

  // PC register and memory response driver, just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (pc_wr_s) pc_reg = redir_s ? tgt_s : pc_reg + 32'd4;
      pc_wr_s = 1'b0;
      mem_ready = pend && (cyc == due);
      if (mem_ready) begin
        mem_rdata = mem_data(pend_addr);
        pend = 1'b0;
      end else begin
        mem_rdata = $urandom;
      end
    end
  end

  // Mid-cycle monitor: captures requests and PC writes, scores consumed slots.
  initial begin
    forever begin
      @(negedge clk);
      pc_wr_s = pc_wr;
      redir_s = redirect;
      tgt_s   = target;
      if (!reset) begin
        if (pc_wr) pc_wr_cnt++;
        if (mem_req) begin
          pend      = 1'b1;
          due       = cyc + cur_lat;
          pend_addr = mem_addr;
          if (rand_lat) cur_lat = $urandom_range(1, 4);
        end
        if (sb_on && if_valid && !id_stall) begin
          take_q.push_back(cyc);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL slot_unexpected: got exc=%b pc=%h instr=%h, required no slot", if_exc, if_pc, if_instr);
          end else begin
            exp_w = exp_q.pop_front();
            if ({if_exc, if_pc, if_instr} !== exp_w)
              begin
                errors++;
                $display("FAIL slot_data: got exc=%b pc=%h instr=%h, required exc=%b pc=%h instr=%h",
                         if_exc, if_pc, if_instr, exp_w[64], exp_w[63:32], exp_w[31:0]);
              end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    step();
    reset = 1'b1; redirect = 1'b0; id_stall = 1'b0; sb_on = 1'b0;
    pend = 1'b0; mem_ready = 1'b0; rand_lat = 1'b0; cur_lat = 1;
    exp_q.delete(); take_q.delete();
    repeat (2) step();
    pc_reg = start_pc; pc_wr_s = 1'b0; pc_wr_cnt = 0;
    reset = 1'b0;
  endtask

  task automatic wait_exp(input string name, input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      step();
      n++;
    end
    sb_on = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d expected slots outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 8;
    if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d, required %0d", dbg_state, IDLE); end
    if (pc_wr !== 1'b0)     begin errors++; $display("FAIL rst_pc_wr: got %b, required 0", pc_wr); end
    if (mem_req !== 1'b0)   begin errors++; $display("FAIL rst_mem_req: got %b, required 0", mem_req); end
    if (mem_addr !== '0)    begin errors++; $display("FAIL rst_mem_addr: got %h, required 0", mem_addr); end
    if (if_valid !== 1'b0)  begin errors++; $display("FAIL rst_if_valid: got %b, required 0", if_valid); end
    if (if_instr !== '0)    begin errors++; $display("FAIL rst_if_instr: got %h, required 0", if_instr); end
    if (if_pc !== '0)       begin errors++; $display("FAIL rst_if_pc: got %h, required 0", if_pc); end
    if (if_exc !== 1'b0)    begin errors++; $display("FAIL rst_if_exc: got %b, required 0", if_exc); end
    step();
    reset = 1'b0; pc_reg = '0; pc_wr_s = 1'b0;
    @(negedge clk);
    checks += 2;
    if (dbg_state !== IDLE || mem_req !== 1'b0) begin
      errors++; $display("FAIL post_rst_idle: got state=%0d mem_req=%b, required state=%0d mem_req=0", dbg_state, mem_req, IDLE);
    end
    if (pc_wr !== 1'b0) begin errors++; $display("FAIL idle_pc_wr: got %b, required 0", pc_wr); end
    step();
    @(negedge clk);
    checks++;
    if (dbg_state !== FETCH || mem_req !== 1'b1) begin
      errors++; $display("FAIL idle_to_fetch: got state=%0d mem_req=%b, required state=%0d mem_req=1", dbg_state, mem_req, FETCH);
    end
  endtask

  task automatic test_sequential();
    do_reset(32'h0);
    sb_on = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 32'(4 * i), mem_data(32'(4 * i))});
    wait_exp("seq", 40);
    checks += 2;
    if (take_q.size() != 3 || take_q[1] - take_q[0] != 2 || take_q[2] - take_q[1] != 2) begin
      errors++; $display("FAIL seq_spacing: got %0d slots with non-2-cycle spacing, required 3 slots 2 cycles apart", take_q.size());
    end
    if (pc_wr_cnt != 3) begin errors++; $display("FAIL seq_pc_wr_count: got %0d, required 3", pc_wr_cnt); end
  endtask

  task automatic test_latency();
    int t0 = -1;
    int t1 = -1;
    do_reset(32'h100);
    cur_lat = 5; sb_on = 1'b1;
    exp_q.push_back({1'b0, 32'h100, 32'hDEAD_BEEF});
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (mem_req) begin t0 = cyc; break; end
    end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (if_valid) begin t1 = cyc; break; end
    end
    checks++;
    if (t0 < 0 || t1 < 0 || t1 - t0 != 6) begin
      errors++; $display("FAIL lat5_req_to_valid: got %0d cycles, required 6", t1 - t0);
    end
    wait_exp("lat5", 20);
  endtask

  task automatic test_stall_hold();
    int n = 0;
    do_reset(32'h40);
    id_stall = 1'b1; sb_on = 1'b1;
    exp_q.push_back({1'b0, 32'h40, mem_data(32'h40)});
    exp_q.push_back({1'b0, 32'h44, mem_data(32'h44)});
    while (dbg_state !== HOLD && n < 20) begin step(); n++; end
    checks++;
    if (dbg_state !== HOLD) begin errors++; $display("FAIL hold_reached: got state %0d, required %0d", dbg_state, HOLD); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks += 2;
      if (dbg_state !== HOLD || pc_wr !== 1'b0) begin
        errors++; $display("FAIL hold_stalled: got state=%0d pc_wr=%b, required state=%0d pc_wr=0", dbg_state, pc_wr, HOLD);
      end
      if (if_valid !== 1'b1 || if_pc !== 32'h40) begin
        errors++; $display("FAIL hold_slot_kept: got valid=%b pc=%h, required valid=1 pc=00000040", if_valid, if_pc);
      end
      step();
    end
    id_stall = 1'b0; pc_wr_cnt = 0;
    @(negedge clk);
    checks++;
    if (pc_wr !== 1'b1) begin errors++; $display("FAIL hold_release_pc_wr: got %b, required 1", pc_wr); end
    step();
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h44 || dbg_state !== FETCH) begin
      errors++; $display("FAIL hold_release_slot: got valid=%b pc=%h state=%0d, required valid=1 pc=00000044 state=%0d",
                         if_valid, if_pc, dbg_state, FETCH);
    end
    step();
    checks++;
    if (pc_wr_cnt != 1) begin errors++; $display("FAIL hold_release_pulses: got %0d, required 1", pc_wr_cnt); end
    wait_exp("hold", 20);
  endtask

  task automatic test_redirect_drop();
    do_reset(32'h100);
    cur_lat = 3; sb_on = 1'b1;
    exp_q.push_back({1'b0, 32'h200, mem_data(32'h200)});
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    step();
    redirect = 1'b1; target = 32'h200;
    @(negedge clk);
    checks++;
    if (pc_wr !== 1'b1 || dbg_state !== WAIT) begin
      errors++; $display("FAIL drop_redirect: got pc_wr=%b state=%0d, required pc_wr=1 state=%0d", pc_wr, dbg_state, WAIT);
    end
    step();
    redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state !== DROP || if_valid !== 1'b0) begin
      errors++; $display("FAIL drop_state: got state=%0d valid=%b, required state=%0d valid=0", dbg_state, if_valid, DROP);
    end
    wait_exp("drop", 40);
  endtask

  task automatic test_redirect_ready();
    int n = 0;
    do_reset(32'h300);
    cur_lat = 2; sb_on = 1'b1;
    exp_q.push_back({1'b0, 32'h400, mem_data(32'h400)});
    step();
    while (!mem_ready && n < 20) begin step(); n++; end
    redirect = 1'b1; target = 32'h400;
    @(negedge clk);
    checks++;
    if (pc_wr !== 1'b1 || dbg_state !== WAIT || mem_ready !== 1'b1) begin
      errors++; $display("FAIL rdr_ready_cycle: got pc_wr=%b state=%0d ready=%b, required pc_wr=1 state=%0d ready=1",
                         pc_wr, dbg_state, mem_ready, WAIT);
    end
    step();
    redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b0 || dbg_state !== FETCH || mem_req !== 1'b1 || mem_addr !== 32'h400) begin
      errors++; $display("FAIL rdr_ready_next: got valid=%b state=%0d req=%b addr=%h, required valid=0 state=%0d req=1 addr=00000400",
                         if_valid, dbg_state, mem_req, mem_addr, FETCH);
    end
    wait_exp("rdr_ready", 20);
  endtask

  task automatic test_align();
    do_reset(32'h102);
    sb_on = 1'b1;
`ifdef FETCH_ALIGN_CHK_EN
    exp_q.push_back({1'b1, 32'h102, NOP});
    @(negedge clk);
    step();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || pc_wr !== 1'b0) begin
      errors++; $display("FAIL align_no_req: got req=%b pc_wr=%b, required req=0 pc_wr=0", mem_req, pc_wr);
    end
    step();
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b1 || if_exc !== 1'b1 || if_instr !== NOP || if_pc !== 32'h102) begin
      errors++; $display("FAIL align_slot: got valid=%b exc=%b instr=%h pc=%h, required valid=1 exc=1 instr=00000013 pc=00000102",
                         if_valid, if_exc, if_instr, if_pc);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || if_valid !== 1'b0) begin
        errors++; $display("FAIL align_halted: got req=%b valid=%b, required req=0 valid=0", mem_req, if_valid);
      end
    end
    checks++;
    if (pc_wr_cnt != 0) begin errors++; $display("FAIL align_pc_wr: got %0d pulses, required 0", pc_wr_cnt); end
    exp_q.push_back({1'b0, 32'h200, mem_data(32'h200)});
    step();
    redirect = 1'b1; target = 32'h200;
    @(negedge clk);
    checks++;
    if (pc_wr !== 1'b1) begin errors++; $display("FAIL align_redirect_pc_wr: got %b, required 1", pc_wr); end
    step();
    redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
      errors++; $display("FAIL align_resume: got req=%b addr=%h, required req=1 addr=00000200", mem_req, mem_addr);
    end
    wait_exp("align", 20);
`else
    exp_q.push_back({1'b0, 32'h102, mem_data(32'h100)});
    @(negedge clk);
    step();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      errors++; $display("FAIL noalign_addr: got req=%b addr=%h, required req=1 addr=00000100", mem_req, mem_addr);
    end
    wait_exp("noalign", 20);
`endif
  endtask

  task automatic test_back_to_back();
    int n = 0;
    do_reset(32'h1000);
    rand_lat = 1'b1; cur_lat = $urandom_range(1, 4); sb_on = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, 32'h1000 + 32'(4 * i), mem_data(32'h1000 + 32'(4 * i))});
    while (exp_q.size() != 0 && n < 300) begin
      step();
      id_stall = ($urandom_range(0, 2) == 0);
      n++;
    end
    id_stall = 1'b0;
    wait_exp("b2b", 20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential();
    test_latency();
    test_stall_hold();
    test_redirect_drop();
    test_redirect_ready();
    test_align();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
